// File: rtl/ram_fifo_pkg.sv
// Shared constants for the RAM-backed valid/ready FIFO.
// The optional RAM_FIFO_WATERMARK_EN build adds the max_count port to ram_fifo.
package ram_fifo_pkg;

    localparam int PF_DEPTH = 2;
    localparam int PF_CNT_W = $clog2(PF_DEPTH + 1);

    function automatic int cnt_w(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/ram_fifo_ram.sv
// Simple dual-port RAM: one write port and one read port with a registered,
// one-cycle-latency read. Contents are not affected by rst.
module ram #(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 2048,
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] w_addr,
    input  logic [WIDTH-1:0]     w_data,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] r_addr,
    output logic [WIDTH-1:0]     r_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] r_data_q;

    always_ff @(posedge clk) begin
        if (we) mem_q[w_addr] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (rst)     r_data_q <= '0;
        else if (re) r_data_q <= mem_q[r_addr];
    end

    assign r_data = r_data_q;

endmodule

// File: rtl/ram_fifo.sv
// RAM-backed valid/ready FIFO with a two-entry prefetch queue hiding the read latency.
// Defining RAM_FIFO_WATERMARK_EN adds a registered peak-occupancy output max_count.
module ram_fifo
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int DEPTH     = 2048,
    parameter int ADDR_BITS = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [cnt_w(ADDR_BITS)-1:0]   count,
    output logic                          empty,
    output logic                          full
`ifdef RAM_FIFO_WATERMARK_EN
    ,
    output logic [cnt_w(ADDR_BITS)-1:0]   max_count
`endif
);

    localparam int                   CW       = cnt_w(ADDR_BITS);
    localparam logic [CW-1:0]        DEPTH_C  = CW'(DEPTH);
    localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(DEPTH - 1);

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        ram_cnt_q, ram_cnt_d, count_q, count_d;
    logic                 inflight_q, inflight_d;
    logic [PF_CNT_W-1:0]  pf_cnt_q, pf_cnt_d;
    logic [WIDTH-1:0]     head_q, head_d, skid_q, skid_d;
    logic                 empty_q, full_q;
    logic [WIDTH-1:0]     r_data;
    logic [2:0]           pf_need;
    logic                 push, pop, issue;

    function automatic logic [ADDR_BITS-1:0] ptr_inc(input logic [ADDR_BITS-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = !rst && (ram_cnt_q != DEPTH_C);
    assign out_valid = (pf_cnt_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Words the prefetch queue will hold once the in-flight read lands and the pop leaves.
    assign pf_need = 3'(pf_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign issue   = (ram_cnt_q != '0) && (pf_need < 3'd2);

    ram #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .we     (push),
        .w_addr (wr_ptr_q),
        .w_data (in_data),
        .re     (issue),
        .r_addr (rd_ptr_q),
        .r_data (r_data)
    );

    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        pf_cnt_d = pf_cnt_q;
        if (pop) begin
            head_d   = skid_q;
            pf_cnt_d = pf_cnt_q - 1'b1;
        end
        // Returning read data takes the first free slot after the pop shift.
        if (inflight_q) begin
            if (pf_cnt_d == '0) head_d = r_data;
            else                skid_d = r_data;
            pf_cnt_d = pf_cnt_d + 1'b1;
        end
    end

    assign wr_ptr_d   = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    assign rd_ptr_d   = issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    assign inflight_d = issue;
    assign ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(issue);
    assign count_d    = ram_cnt_d + CW'(inflight_d) + CW'(pf_cnt_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            pf_cnt_q   <= '0;
            head_q     <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            pf_cnt_q   <= pf_cnt_d;
            head_q     <= head_d;
            count_q    <= count_d;
            empty_q    <= (count_d == '0);
            full_q     <= (ram_cnt_d == DEPTH_C);
        end
    end

    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign out_data = head_q;
    assign count    = count_q;
    assign empty    = empty_q;
    assign full     = full_q;

`ifdef RAM_FIFO_WATERMARK_EN
    logic [CW-1:0] max_count_q;

    always_ff @(posedge clk) begin
        if (rst)                       max_count_q <= '0;
        else if (count_q > max_count_q) max_count_q <= count_q;
    end

    assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_ram_fifo.sv
// Scoreboard bench for ram_fifo: a default-size instance plus DEPTH=4 and DEPTH=5 instances.
// Build with RAM_FIFO_WATERMARK_EN to also exercise max_count.
module tb_ram_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Default instance (WIDTH 64, DEPTH 2048)
    logic        b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_empty, b_full;
    logic [63:0] b_in_data = '0, b_out_data, b_exp;
    logic [11:0] b_count;
`ifdef RAM_FIFO_WATERMARK_EN
    logic [11:0] b_max;
`endif
    logic [63:0] b_q [$];

    // DEPTH=4 instance
    logic        f_in_valid = 0, f_in_ready, f_out_valid, f_out_ready = 0, f_empty, f_full;
    logic [15:0] f_in_data = '0, f_out_data, f_exp;
    logic [2:0]  f_count;
`ifdef RAM_FIFO_WATERMARK_EN
    logic [2:0]  f_max;
`endif
    logic [15:0] f_q [$];

    // DEPTH=5 instance
    logic        v_in_valid = 0, v_in_ready, v_out_valid, v_out_ready = 0, v_empty, v_full;
    logic [15:0] v_in_data = '0, v_out_data, v_exp;
    logic [3:0]  v_count;
`ifdef RAM_FIFO_WATERMARK_EN
    logic [3:0]  v_max;
`endif
    logic [15:0] v_q [$];
    int          v_rcv = 0;

    ram_fifo u_big (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .count(b_count), .empty(b_empty), .full(b_full)
`ifdef RAM_FIFO_WATERMARK_EN
        , .max_count(b_max)
`endif
    );

    ram_fifo #(.WIDTH(16), .DEPTH(4), .ADDR_BITS(2)) u_d4 (
        .clk(clk), .rst(rst),
        .in_valid(f_in_valid), .in_ready(f_in_ready), .in_data(f_in_data),
        .out_valid(f_out_valid), .out_ready(f_out_ready), .out_data(f_out_data),
        .count(f_count), .empty(f_empty), .full(f_full)
`ifdef RAM_FIFO_WATERMARK_EN
        , .max_count(f_max)
`endif
    );

    ram_fifo #(.WIDTH(16), .DEPTH(5), .ADDR_BITS(3)) u_d5 (
        .clk(clk), .rst(rst),
        .in_valid(v_in_valid), .in_ready(v_in_ready), .in_data(v_in_data),
        .out_valid(v_out_valid), .out_ready(v_out_ready), .out_data(v_out_data),
        .count(v_count), .empty(v_empty), .full(v_full)
`ifdef RAM_FIFO_WATERMARK_EN
        , .max_count(v_max)
`endif
    );

    // Scoreboards: pops are checked against the oldest accepted word before this cycle's push is queued.
    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            n_cmp++;
            if (b_q.size() == 0) begin
                n_fail++; $display("FAIL big_order: popped %h, required no output", b_out_data);
            end else begin
                b_exp = b_q.pop_front();
                if (b_out_data !== b_exp) begin
                    n_fail++; $display("FAIL big_order: got %h want %h", b_out_data, b_exp);
                end
            end
        end
        if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
    end

    always @(negedge clk) begin
        if (f_out_valid && f_out_ready) begin
            n_cmp++;
            if (f_q.size() == 0) begin
                n_fail++; $display("FAIL d4_order: popped %h, required no output", f_out_data);
            end else begin
                f_exp = f_q.pop_front();
                if (f_out_data !== f_exp) begin
                    n_fail++; $display("FAIL d4_order: got %h want %h", f_out_data, f_exp);
                end
            end
        end
        if (f_in_valid && f_in_ready) f_q.push_back(f_in_data);
    end

    always @(negedge clk) begin
        if (v_out_valid && v_out_ready) begin
            n_cmp++;
            v_rcv++;
            if (v_q.size() == 0) begin
                n_fail++; $display("FAIL d5_order: popped %h, required no output", v_out_data);
            end else begin
                v_exp = v_q.pop_front();
                if (v_out_data !== v_exp) begin
                    n_fail++; $display("FAIL d5_order: got %h want %h", v_out_data, v_exp);
                end
            end
        end
        if (v_in_valid && v_in_ready) v_q.push_back(v_in_data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", b_in_ready); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", b_out_valid); end
        n_cmp++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", b_empty); end
        n_cmp++; if (b_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", b_full); end
        n_cmp++; if (b_count !== 12'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", b_count); end
        n_cmp++; if (b_out_data !== 64'd0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", b_out_data); end
        n_cmp++; if (f_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_d4_in_ready: got %b want 0", f_in_ready); end
        rst = 1'b0;
        tick();
        n_cmp++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready: got %b want 1", b_in_ready); end
        n_cmp++; if (v_in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_d5_in_ready: got %b want 1", v_in_ready); end
    endtask

    task automatic test_single();
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 64'hA5;
        tick();
        b_in_valid = 1'b0;
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_v0: got %b want 0", b_out_valid); end
        n_cmp++; if (b_count !== 12'd1) begin n_fail++; $display("FAIL single_cnt0: got %0d want 1", b_count); end
        tick();
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_v1: got %b want 0", b_out_valid); end
        n_cmp++; if (b_count !== 12'd1) begin n_fail++; $display("FAIL single_cnt1: got %0d want 1", b_count); end
        tick();
        n_cmp++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL single_v2: got %b want 1", b_out_valid); end
        n_cmp++; if (b_out_data !== 64'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", b_out_data); end
        n_cmp++; if (b_count !== 12'd1) begin n_fail++; $display("FAIL single_cnt2: got %0d want 1", b_count); end
        tick();
        n_cmp++; if (b_count !== 12'd0) begin n_fail++; $display("FAIL single_cnt3: got %0d want 0", b_count); end
        n_cmp++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b want 1", b_empty); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL single_v3: got %b want 0", b_out_valid); end
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        b_out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            b_in_valid = (c < 10);
            b_in_data  = 64'(c);
            tick();
            exp_v = (c >= 2) && (c <= 11);
            n_cmp++;
            if (b_out_valid !== exp_v) begin
                n_fail++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, b_out_valid, exp_v);
            end
            if (exp_v) begin
                n_cmp++;
                if (b_out_data !== 64'(c - 2)) begin
                    n_fail++; $display("FAIL b2b_data[%0d]: got %0d want %0d", c, b_out_data, c - 2);
                end
            end
        end
        b_in_valid = 1'b0;
    endtask

    task automatic test_full_d4();
        int  nxt;
        logic go;
        nxt = 0;
        f_out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            f_in_valid = 1'b1;
            f_in_data  = 16'(nxt + 16'h40);
            go = f_in_ready;
            tick();
            if (go) nxt++;
        end
        n_cmp++; if (nxt != 6) begin n_fail++; $display("FAIL d4_accepted: got %0d want 6", nxt); end
        n_cmp++; if (f_full !== 1'b1) begin n_fail++; $display("FAIL d4_full: got %b want 1", f_full); end
        n_cmp++; if (f_in_ready !== 1'b0) begin n_fail++; $display("FAIL d4_in_ready_full: got %b want 0", f_in_ready); end
        n_cmp++; if (f_count !== 3'd6) begin n_fail++; $display("FAIL d4_count: got %0d want 6", f_count); end
        // Push refused while full, pop taken in the same cycle.
        f_out_ready = 1'b1;
        tick();
        f_in_valid = 1'b0;
        n_cmp++; if (f_in_ready !== 1'b1) begin n_fail++; $display("FAIL d4_in_ready_after_pop: got %b want 1", f_in_ready); end
        n_cmp++; if (f_full !== 1'b0) begin n_fail++; $display("FAIL d4_full_after_pop: got %b want 0", f_full); end
        repeat (10) tick();
        n_cmp++; if (f_empty !== 1'b1) begin n_fail++; $display("FAIL d4_drain_empty: got %b want 1", f_empty); end
        n_cmp++; if (f_q.size() != 0) begin n_fail++; $display("FAIL d4_drain_left: got %0d want 0", f_q.size()); end
        f_out_ready = 1'b0;
    endtask

    task automatic test_wrap_d5();
        int  sent;
        logic go;
        sent  = 0;
        v_rcv = 0;
        for (int cyc = 0; cyc < 600 && (sent < 23 || v_rcv < 23); cyc++) begin
            v_in_valid  = (sent < 23) && ($urandom_range(2) != 0);
            v_in_data   = 16'(16'h1000 + sent * 3);
            v_out_ready = ($urandom_range(1) != 0);
            go = v_in_valid && v_in_ready;
            tick();
            if (go) sent++;
        end
        v_in_valid  = 1'b0;
        v_out_ready = 1'b0;
        n_cmp++; if (v_rcv != 23) begin n_fail++; $display("FAIL d5_received: got %0d want 23", v_rcv); end
        n_cmp++; if (v_q.size() != 0) begin n_fail++; $display("FAIL d5_left: got %0d want 0", v_q.size()); end
        n_cmp++; if (v_empty !== 1'b1) begin n_fail++; $display("FAIL d5_empty: got %b want 1", v_empty); end
    endtask

    task automatic test_reset_inflight();
        b_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 64'(64'h100 + i);
            tick();
        end
        b_in_valid = 1'b0;
        n_cmp++; if (b_count !== 12'd3) begin n_fail++; $display("FAIL rif_pre_count: got %0d want 3", b_count); end
        rst = 1'b1;
        tick();
        b_q.delete();
        f_q.delete();
        v_q.delete();
        n_cmp++; if (b_count !== 12'd0) begin n_fail++; $display("FAIL rif_count: got %0d want 0", b_count); end
        n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rif_out_valid: got %b want 0", b_out_valid); end
        n_cmp++; if (b_out_data !== 64'd0) begin n_fail++; $display("FAIL rif_out_data: got %h want 0", b_out_data); end
        n_cmp++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL rif_in_ready: got %b want 0", b_in_ready); end
        rst = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL rif_stale[%0d]: got %b want 0", i, b_out_valid); end
        end
        b_in_valid = 1'b1;
        b_in_data  = 64'h77;
        tick();
        b_in_valid = 1'b0;
        repeat (4) tick();
        n_cmp++; if (b_q.size() != 0) begin n_fail++; $display("FAIL rif_after_left: got %0d want 0", b_q.size()); end
        n_cmp++; if (b_empty !== 1'b1) begin n_fail++; $display("FAIL rif_after_empty: got %b want 1", b_empty); end
    endtask

`ifdef RAM_FIFO_WATERMARK_EN
    task automatic test_watermark();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (b_max !== 12'd0) begin n_fail++; $display("FAIL wm_init: got %0d want 0", b_max); end
        b_out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 64'(64'h200 + i);
            tick();
        end
        b_in_valid = 1'b0;
        repeat (3) tick();
        n_cmp++; if (b_count !== 12'd7) begin n_fail++; $display("FAIL wm_peak_count: got %0d want 7", b_count); end
        b_out_ready = 1'b1;
        repeat (12) tick();
        n_cmp++; if (b_max !== 12'd7) begin n_fail++; $display("FAIL wm_after_drain: got %0d want 7", b_max); end
        repeat (5) tick();
        n_cmp++; if (b_max !== 12'd7) begin n_fail++; $display("FAIL wm_hold: got %0d want 7", b_max); end
        rst = 1'b1;
        tick();
        b_q.delete();
        n_cmp++; if (b_max !== 12'd0) begin n_fail++; $display("FAIL wm_rst: got %0d want 0", b_max); end
        rst = 1'b0;
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full_d4();
        test_wrap_d5();
        test_reset_inflight();
`ifdef RAM_FIFO_WATERMARK_EN
        test_watermark();
`endif
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
